simple_circuit: RTL and testbench

//  Registered gate-level logic cell computing D = (A & B) | ~C and E = ~C per bit lane.

---
 rtl/simple_circuit_lane.sv | 13 +
 rtl/simple_circuit.sv | 39 +++
 tb/tb_simple_circuit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/simple_circuit_lane.sv
// simple_circuit_lane: scalar gate cell, d = (a & b) | ~c, e = ~c
module simple_circuit_lane (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic d,
    output logic e
);
    logic w1;
    and g1 (w1, a, b);
    not g2 (e, c);
    or  g3 (d, w1, e);
endmodule

// File: rtl/simple_circuit.sv
// simple_circuit: WIDTH parallel gate lanes with optional one-cycle output register and valid flag
module simple_circuit #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e
);
    logic [WIDTH-1:0] d_c;
    logic [WIDTH-1:0] e_c;
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        simple_circuit_lane u_lane (
            .a(a[i]),
            .b(b[i]),
            .c(c[i]),
            .d(d_c[i]),
            .e(e_c[i])
        );
    end
    if (REG_OUT) begin : g_reg
        // register results every cycle; valid only qualifies, reset clears everything
        always_ff @(posedge clk) begin
            out_valid <= rst ? 1'b0 : in_valid;
            d         <= rst ? '0 : d_c;
            e         <= rst ? '0 : e_c;
        end
    end else begin : g_comb
        assign out_valid = in_valid;
        assign d         = d_c;
        assign e         = e_c;
    end
endmodule

// File: tb/tb_simple_circuit.sv
// tb_simple_circuit: scoreboard bench for registered scalar/4-lane cells plus a combinational variant
module tb_simple_circuit;
    typedef struct {
        logic       ev;
        logic [3:0] ed;
        logic [3:0] ee;
    } item_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] a = '0, b = '0, c = '0;
    logic       ov1, ov4, ovc;
    logic [0:0] d1, e1;
    logic [3:0] d4, e4, dc, ec;
    logic       ivc = 1'b0;
    logic [3:0] ac = '0, bc = '0, cc = '0;
    logic       rstc = 1'b1;
    item_t      q[$];
    int         checks = 0;
    int         passed = 0;

    always #5 clk = ~clk;

    simple_circuit #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a[0]), .b(b[0]), .c(c[0]),
        .out_valid(ov1), .d(d1), .e(e1)
    );
    simple_circuit #(.WIDTH(4), .REG_OUT(1'b1)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c),
        .out_valid(ov4), .d(d4), .e(e4)
    );
    simple_circuit #(.WIDTH(4), .REG_OUT(1'b0)) u_comb (
        .clk(clk), .rst(rstc), .in_valid(ivc), .a(ac), .b(bc), .c(cc),
        .out_valid(ovc), .d(dc), .e(ec)
    );

    task automatic drive(input logic r, input logic iv, input logic [3:0] a_i, b_i, c_i,
                         input logic ev, input logic [3:0] ed, ee);
        item_t it;
        @(negedge clk);
        rst = r;
        in_valid = iv;
        a = a_i;
        b = b_i;
        c = c_i;
        it.ev = ev;
        it.ed = ed;
        it.ee = ee;
        q.push_back(it);
    endtask

    task automatic check_comb(input string name, input logic ev, input logic [3:0] ed, ee);
        checks++;
        if (ovc !== ev || dc !== ed || ec !== ee)
            $display("FAIL %s: got v=%b d=%b e=%b, want v=%b d=%b e=%b", name, ovc, dc, ec, ev, ed, ee);
        else
            passed++;
    endtask

    // monitor: compare registered outputs one cycle after each issued sample
    initial begin
        item_t it;
        int    n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                it = q.pop_front();
                checks++;
                if (ov4 !== it.ev || d4 !== it.ed || e4 !== it.ee ||
                    ov1 !== it.ev || d1[0] !== it.ed[0] || e1[0] !== it.ee[0])
                    $display("FAIL item%0d: got w4 v=%b d=%b e=%b w1 v=%b d=%b e=%b, want v=%b d=%b e=%b",
                             n, ov4, d4, e4, ov1, d1, e1, it.ev, it.ed, it.ee);
                else
                    passed++;
                n++;
            end
        end
    end

    initial begin
        logic [7:0] tt_d = 8'b1101_0101;
        logic [7:0] tt_e = 8'b0101_0101;
        int         waited = 0;
        drive(1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 1'b0, 4'h0, 4'h0);
        drive(1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 1'b0, 4'h0, 4'h0);
        drive(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 4'hF, 4'hF);
        drive(1'b0, 1'b1, 4'hF, 4'hF, 4'hF, 1'b1, 4'hF, 4'h0);
        drive(1'b0, 1'b1, 4'hF, 4'h0, 4'hF, 1'b1, 4'h0, 4'h0);
        for (int k = 0; k < 8; k++)
            drive(1'b0, 1'b1, {4{k[2]}}, {4{k[1]}}, {4{k[0]}}, 1'b1, {4{tt_d[k]}}, {4{tt_e[k]}});
        drive(1'b0, 1'b1, 4'b1100, 4'b1010, 4'b0110, 1'b1, 4'b1001, 4'b1001);
        drive(1'b0, 1'b1, 4'b0011, 4'b0101, 4'b1001, 1'b1, 4'b0111, 4'b0110);
        drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'hF, 4'hF);
        drive(1'b0, 1'b1, 4'b1100, 4'b1010, 4'b0110, 1'b1, 4'b1001, 4'b1001);
        drive(1'b1, 1'b1, 4'b1100, 4'b1010, 4'b0110, 1'b0, 4'h0, 4'h0);
        drive(1'b0, 1'b1, 4'b1100, 4'b1010, 4'b0110, 1'b1, 4'b1001, 4'b1001);
        drive(1'b0, 1'b0, 4'hF, 4'hF, 4'hF, 1'b0, 4'hF, 4'h0);
        while (q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d items left, want 0", q.size());
        end
        ivc = 1'b1;
        ac = 4'h0;
        bc = 4'h0;
        cc = 4'h0;
        #1 check_comb("comb_c0", 1'b1, 4'hF, 4'hF);
        cc = 4'hF;
        #1 check_comb("comb_c1", 1'b1, 4'h0, 4'h0);
        ac = 4'hF;
        bc = 4'hF;
        ivc = 1'b0;
        #1 check_comb("comb_111", 1'b0, 4'hF, 4'h0);
        ac = 4'b1100;
        bc = 4'b1010;
        cc = 4'b0110;
        #1 check_comb("comb_lanes", 1'b0, 4'b1001, 4'b1001);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
